// File: rtl/word_serializer.sv
// Word-to-chunk serializer: emits the enabled CHUNK_W slices of a registered word, lowest index first.
// Optional back-to-back loading during the final handshake is enabled by WORD_SERIALIZER_PIPE_EN.
module word_serializer #(
   parameter  int WORD_W  = 32,
   parameter  int CHUNK_W = 8,
   localparam int CHUNKS  = WORD_W / CHUNK_W,
   localparam int IDX_W   = (CHUNKS > 2) ? $clog2(CHUNKS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [0:WORD_W-1]  d_in,
   input  logic [0:CHUNKS-1]  en_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:CHUNK_W-1] d_out,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last
);

   if (((WORD_W % CHUNK_W) != 0) || (CHUNKS < 2)) begin : g_bad_cfg
      $error("word_serializer: WORD_W must be a multiple of CHUNK_W giving at least two chunks");
   end

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t              state, state_n;
   logic [0:WORD_W-1]   word_q, word_n;
   logic [0:CHUNKS-1]   mask_q, mask_n;
   logic [0:CHUNK_W-1]  d_out_q, d_out_n;
   logic [IDX_W-1:0]    idx_q, idx_n;
   logic                last_q, last_n;

   logic                accept;
   logic                advance;
   logic                finish;
   logic [0:CHUNKS-1]   pick_mask;
   logic [0:CHUNKS-1]   p_rem;
   logic                p_found;
   logic [IDX_W-1:0]    p_idx;
   logic [0:CHUNK_W-1]  p_chunk;

   logic [0:CHUNK_W-1]  in_chunk   [CHUNKS];
   logic [0:CHUNK_W-1]  word_chunk [CHUNKS];

   for (genvar g = 0; g < CHUNKS; g++) begin : g_split
      assign in_chunk[g]   = d_in[g*CHUNK_W +: CHUNK_W];
      assign word_chunk[g] = word_q[g*CHUNK_W +: CHUNK_W];
   end

`ifdef WORD_SERIALIZER_PIPE_EN
   assign in_ready = !reset && ((state == IDLE) || ((state == SEND) && last_q && out_ready));
`else
   assign in_ready = !reset && (state == IDLE);
`endif

   assign accept    = in_valid && in_ready;
   assign advance   = (state == SEND) && out_ready && !last_q;
   assign finish    = (state == SEND) && out_ready && last_q;
   assign out_valid = (state == SEND);
   assign d_out     = d_out_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;

   // A single priority pick serves both a fresh word (from the inputs) and the next chunk of the held word.
   always_comb begin
      pick_mask = accept ? en_in : mask_q;
      p_rem     = pick_mask;
      p_found   = 1'b0;
      p_idx     = '0;
      p_chunk   = '0;
      for (int unsigned k = 0; k < CHUNKS; k++) begin
         if (!p_found && pick_mask[k]) begin
            p_found  = 1'b1;
            p_idx    = IDX_W'(k);
            p_chunk  = accept ? in_chunk[k] : word_chunk[k];
            p_rem[k] = 1'b0;
         end
      end
   end

   always_comb begin
      state_n = state;
      word_n  = word_q;
      mask_n  = mask_q;
      d_out_n = d_out_q;
      idx_n   = idx_q;
      last_n  = last_q;

      if (finish) begin
         state_n = IDLE;
         last_n  = 1'b0;
      end

      if (advance) begin
         d_out_n = p_chunk;
         idx_n   = p_idx;
         mask_n  = p_rem;
         last_n  = (p_rem == '0);
      end

      if (accept) begin
         word_n = d_in;
         mask_n = p_rem;
         if (p_found) begin
            state_n = SEND;
            d_out_n = p_chunk;
            idx_n   = p_idx;
            last_n  = (p_rem == '0);
         end else begin
            state_n = IDLE;
            last_n  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         word_q  <= '0;
         mask_q  <= '0;
         d_out_q <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state   <= state_n;
         word_q  <= word_n;
         mask_q  <= mask_n;
         d_out_q <= d_out_n;
         idx_q   <= idx_n;
         last_q  <= last_n;
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios plus random traffic against a chunk-queue model.
module tb_word_serializer;

   localparam int WORD_W  = 32;
   localparam int CHUNK_W = 8;
   localparam int CHUNKS  = 4;
`ifdef WORD_SERIALIZER_PIPE_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [0:WORD_W-1]  d_in;
   logic [0:CHUNKS-1]  en_in;
   logic               out_valid;
   logic               out_ready;
   logic [0:CHUNK_W-1] d_out;
   logic [1:0]         out_idx;
   logic               out_last;

   word_serializer #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .d_in(d_in), .en_in(en_in), .out_valid(out_valid), .out_ready(out_ready),
      .d_out(d_out), .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] chunk;
      logic [1:0] idx;
      logic       last;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  held_chunk;
   logic [1:0]  held_idx;
   logic [31:0] cur_w;
   logic [3:0]  cur_en;
   logic        acc;
   int          compared = 0;
   int          failed   = 0;
   int          valid_cnt;
   bit          record;
   bit          hist[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expand a word into its enabled chunks: chunk k is the k-th byte from the MSB end,
   // enabled by literal bit (CHUNKS-1-k) of the enable pattern.
   task automatic push_word(input logic [31:0] w, input logic [3:0] en);
      exp_t tmp[$];
      exp_t e;
      for (int k = 0; k < CHUNKS; k++) begin
         if (((en >> (CHUNKS - 1 - k)) & 4'd1) != 0) begin
            e.chunk = 8'((w >> (WORD_W - (k + 1) * CHUNK_W)) & 32'hFF);
            e.idx   = 2'(k);
            e.last  = 1'b0;
            tmp.push_back(e);
         end
      end
      if (tmp.size() != 0) tmp[tmp.size()-1].last = 1'b1;
      foreach (tmp[i]) q.push_back(tmp[i]);
   endtask

   task automatic tick();
      logic exp_ready;
      d_in  = cur_w;
      en_in = cur_en;
      #1;
      exp_ready = !reset && ((q.size() == 0) || (PIPE && (q.size() == 1) && out_ready));
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("d_out", 32'(d_out), 32'(q[0].chunk));
         check("out_idx", 32'(out_idx), 32'(q[0].idx));
         check("out_last", 32'(out_last), 32'(q[0].last));
      end else begin
         check("d_out_hold", 32'(d_out), 32'(held_chunk));
         check("out_idx_hold", 32'(out_idx), 32'(held_idx));
         check("out_last_idle", 32'(out_last), 32'd0);
      end
      valid_cnt += int'(out_valid);
      if (record) hist.push_back(out_valid);
      acc = 1'b0;
      if (reset) begin
         q.delete();
         held_chunk = '0;
         held_idx   = '0;
      end else begin
         if ((q.size() != 0) && out_ready) begin
            held_chunk = q[0].chunk;
            held_idx   = q[0].idx;
            void'(q.pop_front());
         end
         if (in_valid && exp_ready) begin
            acc = 1'b1;
            push_word(cur_w, cur_en);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w, input logic [3:0] en);
      in_valid = 1'b1;
      cur_w    = w;
      cur_en   = en;
      acc      = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) tick();
      in_valid = 1'b0;
      check("accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && q.size() != 0; i++) tick();
      check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   initial begin
      int first_one, last_one, ones, zeros;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      cur_w = '0; cur_en = '0; held_chunk = '0; held_idx = '0;
      valid_cnt = 0; record = 1'b0;
      d_in = '0; en_in = '0;
      @(posedge clk);
      #1;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Full word, free-flowing sink
      send(32'hA1B2C3D4, 4'b1111);
      drain();

      // Sparse enables: only chunks 1 and 3
      valid_cnt = 0;
      send(32'h11223344, 4'b0101);
      drain();
      tick();
      check("sparse_valid_cycles", 32'(valid_cnt), 32'd2);

      // Stall on chunk 1 for three cycles
      send(32'hA1B2C3D4, 4'b1111);
      tick();
      out_ready = 1'b0;
      tick(); tick(); tick();
      check("stall_dout", 32'(d_out), 32'hB2);
      check("stall_idx", 32'(out_idx), 32'd1);
      out_ready = 1'b1;
      drain();

      // Empty enable mask, then an immediate follow-up word
      valid_cnt = 0;
      send(32'hDEADBEEF, 4'b0000);
      check("empty_no_valid", 32'(valid_cnt), 32'd0);
      send(32'h0badcafe, 4'b1001);
      drain();

      // Reset in the middle of a word
      send(32'hCAFEF00D, 4'b1111);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      send(32'h55667788, 4'b1111);
      drain();

      // Back-to-back words
      hist.delete();
      record   = 1'b1;
      in_valid = 1'b1;
      cur_w    = 32'h01020304;
      cur_en   = 4'b1111;
      acc      = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) tick();
      cur_w = 32'h05060708;
      acc   = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) tick();
      in_valid = 1'b0;
      drain();
      tick();
      record = 1'b0;
      first_one = -1; last_one = -1; ones = 0; zeros = 0;
      foreach (hist[i]) if (hist[i]) begin
         if (first_one < 0) first_one = i;
         last_one = i;
         ones++;
      end
      for (int i = first_one; i >= 0 && i <= last_one; i++) if (!hist[i]) zeros++;
      check("b2b_valid_cycles", 32'(ones), 32'd8);
      check("b2b_bubbles", 32'(zeros), PIPE ? 32'd0 : 32'd1);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         cur_w     = $urandom;
         cur_en    = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, input word width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 8, output chunk width in bits; CHUNKS = WORD_W/CHUNK_W, IDX_W = max(1, clog2(CHUNKS)).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream word offered.
REQ-006 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port d_in  input  [0:WORD_W-1]  word; bit 0 is MSB.
REQ-008 SHALL have port en_in  input  [0:CHUNKS-1]  per-chunk enable; en_in[k] selects chunk k.
REQ-009 SHALL have port out_valid  output  1  chunk presented.
REQ-010 SHALL have port out_ready  input  1  downstream takes chunk.
REQ-011 SHALL have port d_out  output  [0:CHUNK_W-1]  chunk k = word[k*CHUNK_W : k*CHUNK_W+CHUNK_W-1].
REQ-012 SHALL have port out_idx  output  IDX_W  index k of presented chunk.
REQ-013 SHALL have port out_last  output  1  presented chunk is last enabled chunk of word.

Function
REQ-014 SHALL reject (elaboration error) WORD_W not an integer multiple of CHUNK_W, or CHUNKS < 2.
REQ-015 SHALL implement states IDLE and SEND.
REQ-016 Accept SHALL occur when in_valid && in_ready; word and en_in are registered on that edge.
REQ-017 IDLE: in_ready = 1; accept with en_in != 0 -> SEND, first enabled chunk (lowest k) valid on the following cycle (latency 1).
REQ-018 Accept with en_in == 0 SHALL consume the word, emit nothing, remain in IDLE.
REQ-019 SEND: out_valid = 1; chunks emitted in ascending k, disabled chunks skipped with no idle cycles.
REQ-020 On out_valid && out_ready with out_last = 0, SHALL advance to next enabled chunk next cycle.
REQ-021 On out_valid && out_ready with out_last = 1, SHALL return to IDLE (baseline, see REQ-030).
REQ-022 While out_valid && !out_ready, d_out, out_idx, out_last SHALL hold stable.
REQ-023 out_valid SHALL never drop without a completed handshake, except by reset.
REQ-024 in_valid with in_ready = 0 SHALL have no effect; d_in/en_in ignored.
REQ-025 In IDLE, out_valid = 0, out_last = 0; d_out and out_idx hold last values.

Reset
REQ-026 reset high on a clock edge SHALL force IDLE, out_valid = 0, out_last = 0, out_idx = 0, d_out = 0, registered word and mask = 0.
REQ-027 While reset is high, in_ready SHALL be 0; in_ready = 1 from the first cycle after reset deasserts.
REQ-028 Reset mid-word SHALL discard remaining chunks; no chunk emitted after reset.

Configuration
REQ-029 Macro WORD_SERIALIZER_PIPE_EN SHALL select back-to-back operation.
REQ-030 With WORD_SERIALIZER_PIPE_EN defined: in_ready = IDLE || (out_valid && out_last && out_ready) (combinational from out_ready); accept during final handshake loads the new word, staying in SEND (or going to IDLE if new en_in == 0), zero bubble cycles.
REQ-031 Without it: in_ready = 1 only in IDLE; one bubble cycle between words; no combinational path out_ready -> in_ready.

Verification
REQ-032 d_in=32'hA1B2C3D4, en_in=4'b1111, out_ready=1 -> d_out A1,B2,C3,D4 on cycles t+1..t+4, out_idx 0..3, out_last only with D4.
REQ-033 d_in=32'h11223344, en_in=4'b0101 -> d_out 22 (idx 1), 44 (idx 3, last); no cycles for idx 0, 2.
REQ-034 en_in=4'b1111, out_ready low 3 cycles at chunk 1 -> d_out, out_idx held at B2/1 throughout stall, then sequence resumes.
REQ-035 en_in=4'b0000 -> no out_valid, in_ready remains 1, next word accepted following cycle.
REQ-036 Reset asserted after chunk 1 of 4 -> out_valid 0 next cycle, in_ready 0 during reset, 1 after; new word emits from its idx 0.
REQ-037 Two words back-to-back, en_in=4'b1111, out_ready=1 -> PIPE_EN: 8 consecutive valid cycles; without: 4 valid, 1 bubble, 4 valid.
